// File: rtl/keypad_event_scheduler.sv
// keypad_event_scheduler
//   Captures per-key press pulses, arbitrates them round-robin, and queues
//   {repeat, code} events in a show-ahead FIFO that drains over valid/ready.
//   Optional feature: define KEYPAD_REPEAT_EN to add the held-key auto-repeat
//   tracker (lowest-priority 17th requester). Without it evt_repeat is always
//   0 and key_out / REPEAT_* are ignored.

// Per-key capture cell: one pending bit plus drop detection.
module keypad_event_scheduler_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  input  logic grant,
  output logic pend,
  output logic drop
);
  // A pulse on a key that is still pending and not being granted is lost.
  assign drop = pulse & pend & ~grant;

  // Pending bit: grant clears it, a new pulse sets it (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= (pend & ~grant) | pulse;
  end
endmodule

module keypad_event_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 6000000,
  parameter int REPEAT_RATE  = 1200000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 key_out,
  input  logic [15:0]                 key_pulse,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [3:0]                  evt_code,
  output logic                        evt_repeat,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        ovf_clr
);
  localparam int NUM_KEYS = 16;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef struct packed {
    logic       rep;
    logic [3:0] code;
  } evt_t;

  logic [NUM_KEYS-1:0] pending, grant, drop;
  logic [3:0]          rr_ptr, gnt_idx, scan_idx;
  logic                gnt_found, gnt_any, can_accept, pop, push;
  logic                rpt_req, rpt_gnt, rpt_drop;
  logic [3:0]          rpt_key;
  evt_t                push_evt, head;
  evt_t                mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;

  keypad_event_scheduler_lane u_lane [NUM_KEYS-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (key_pulse),
    .grant (grant),
    .pend  (pending),
    .drop  (drop)
  );

  assign pop        = evt_valid & evt_ready;
  // A full FIFO can still take a push in the cycle its head is being popped.
  assign can_accept = (fifo_count < DEPTH_C) | pop;

  // Round-robin search: first pending key at or after rr_ptr, wrapping mod 16.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = rr_ptr;
    for (int k = 0; k < NUM_KEYS; k++) begin
      scan_idx = rr_ptr + 4'(k);
      if (!gnt_found && pending[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign gnt_any = gnt_found & can_accept;
  assign grant   = gnt_any ? (16'h0001 << gnt_idx) : '0;
  // Auto-repeat only goes in when no real press is waiting.
  assign rpt_gnt = rpt_req & ~(|pending) & can_accept;
  assign push    = gnt_any | rpt_gnt;

  // Select the event being written this cycle.
  always_comb begin
    push_evt = '0;
    if (gnt_any) begin
      push_evt.rep  = 1'b0;
      push_evt.code = gnt_idx;
    end else if (rpt_gnt) begin
      push_evt.rep  = 1'b1;
      push_evt.code = rpt_key;
    end
  end

  // Round-robin pointer moves past the key just granted; repeats leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= gnt_idx + 4'd1;
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_evt;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign evt_valid  = (fifo_count != '0);
  assign evt_code   = evt_valid ? head.code : 4'd0;
  assign evt_repeat = evt_valid & head.rep;

  // Sticky overflow: a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow <= 1'b0;
    else if ((|drop) | rpt_drop)     overflow <= 1'b1;
    else if (ovf_clr)                overflow <= 1'b0;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(RPT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RATE} rpt_state_t;

  rpt_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    rpt_key_nxt;
  logic          rpt_req_nxt, expire;

  // Repeat tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rpt_key <= '0;
      rpt_req <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rpt_key <= rpt_key_nxt;
      rpt_req <= rpt_req_nxt;
    end
  end

  // Tracker next state: a fresh press retargets, release stops, timers expire.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rpt_key_nxt = rpt_key;
    rpt_req_nxt = rpt_req & ~rpt_gnt;
    expire      = 1'b0;
    if (gnt_any) begin
      // New press supersedes any outstanding repeat of the old key.
      state_nxt   = DELAY;
      cnt_nxt     = '0;
      rpt_key_nxt = gnt_idx;
      rpt_req_nxt = 1'b0;
    end else if (state != IDLE && key_out[rpt_key]) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      rpt_req_nxt = 1'b0;
    end else begin
      case (state)
        DELAY: begin
          if (cnt == DELAY_LAST) begin
            expire    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RATE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RATE: begin
          if (cnt == RATE_LAST) begin
            expire  = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: ;
      endcase
      if (expire) rpt_req_nxt = 1'b1;
    end
  end

  // Timer expiring while the previous repeat is still waiting loses a repeat.
  assign rpt_drop = expire & rpt_req & ~rpt_gnt;
`else
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_RATE;
  logic unused_key_out;
  assign unused_key_out = ^key_out;
  assign rpt_req  = 1'b0;
  assign rpt_key  = '0;
  assign rpt_drop = 1'b0;
`endif

endmodule
